// File: rtl/gram_pkg.sv
// Shared GRAM geometry, scanner state encoding and the tagged pixel record
// exchanged between GRAM, the scanner and the panel driver.
package gram_pkg;

  localparam int unsigned H_PIX      = 25;
  localparam int unsigned V_PIX      = 15;
  localparam int unsigned GRAM_DEPTH = H_PIX * V_PIX;
  localparam int unsigned PIX_W      = 4;
  localparam int unsigned ADDR_W     = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [PIX_W-1:0] data;
  } pix_tag_t;

endpackage

// File: rtl/gram_scanner_if.sv
// GRAM read port plus tagged pixel stream; the scanner is the master side,
// GRAM/panel driver environment is the slave side.
interface gram_scanner_if;
  import gram_pkg::*;

  logic [ADDR_W-1:0] gram_addr_o;
  logic [PIX_W-1:0]  gram_data_i;
  logic              pix_valid_o;
  logic              pix_ready_i;
  logic [PIX_W-1:0]  pix_data_o;
  logic              pix_sof_o;
  logic              pix_eol_o;

  modport master (
    output gram_addr_o,
    input  gram_data_i,
    output pix_valid_o,
    input  pix_ready_i,
    output pix_data_o,
    output pix_sof_o,
    output pix_eol_o
  );

  modport slave (
    input  gram_addr_o,
    output gram_data_i,
    input  pix_valid_o,
    output pix_ready_i,
    input  pix_data_o,
    input  pix_sof_o,
    input  pix_eol_o
  );

endinterface

// File: rtl/gram_scanner_pix_fifo2.sv
// Two-entry registered FIFO of tagged pixels; absorbs GRAM read latency
// against sink backpressure.
module pix_fifo2
  import gram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  pix_tag_t   i_data,
  input  logic       i_pop,
  output pix_tag_t   o_head,
  output logic [1:0] o_count
);

  pix_tag_t   r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                   !(i_push && !i_pop && (r_count == 2'd2)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(i_pop && (r_count == 2'd0)));

endmodule

// File: rtl/gram_scanner.sv
// Display-side GRAM read master: once per frame tick sweeps the pixel grid
// and emits a raster-ordered, SOF/EOL tagged pixel stream.
module gram_scanner
  import gram_pkg::scan_state_t;
  import gram_pkg::pix_tag_t;
  import gram_pkg::ADDR_W;
  import gram_pkg::IDLE;
  import gram_pkg::SCAN;
  import gram_pkg::DRAIN;
#(
  parameter int unsigned H_PIX     = 25,
  parameter int unsigned V_PIX     = 15,
  parameter int unsigned FRAME_DIV = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  gram_scanner_if.master bus,
  output logic           busy_o,
  output logic           frame_done_o,
  output logic           overrun_o
);

  localparam int unsigned CNT_W  = $clog2(FRAME_DIV);
  localparam int unsigned COL_W  = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int unsigned LINE_W = (V_PIX > 1) ? $clog2(V_PIX) : 1;

  scan_state_t       r_state;
  scan_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic              w_tick;
  logic              w_start;
  logic              w_frame_done;
  logic              r_overrun;

  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_held_addr;
  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic              w_last;
  logic              w_issue;
  logic [1:0]        w_occ;

  logic              r_inflight;
  logic              r_if_sof;
  logic              r_if_eol;

  pix_tag_t          w_bypass_tag;
  pix_tag_t          w_fifo_head;
  pix_tag_t          w_out_tag;
  logic [1:0]        w_fifo_count;
  logic              w_fifo_nonempty;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (!en_i || (r_tick_cnt == CNT_W'(FRAME_DIV - 1))) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  assign w_tick  = en_i && (r_tick_cnt == CNT_W'(FRAME_DIV - 1));
  assign w_start = (r_state == IDLE) && w_tick;

  assign w_occ   = w_fifo_count + {1'b0, r_inflight};
  assign w_issue = (r_state == SCAN) && (w_occ < 2'd2);
  assign w_last  = (r_col == COL_W'(H_PIX - 1)) && (r_line == LINE_W'(V_PIX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE:  if (w_start) w_state_nxt = SCAN;
      SCAN:  if (w_issue && w_last) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!w_fifo_nonempty && !r_inflight) begin
          w_state_nxt  = IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_addr <= '0;
      r_held_addr <= '0;
      r_col       <= '0;
      r_line      <= '0;
    end else if (w_start) begin
      r_next_addr <= '0;
      r_col       <= '0;
      r_line      <= '0;
    end else if (w_issue) begin
      r_held_addr <= r_next_addr;
      r_next_addr <= r_next_addr + ADDR_W'(1);
      if (r_col == COL_W'(H_PIX - 1)) begin
        r_col  <= '0;
        r_line <= (r_line == LINE_W'(V_PIX - 1)) ? '0 : r_line + LINE_W'(1);
      end else begin
        r_col  <= r_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_if_sof   <= 1'b0;
      r_if_eol   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_if_sof   <= w_issue && (r_next_addr == '0);
      r_if_eol   <= w_issue && (r_col == COL_W'(H_PIX - 1));
      if (w_tick && (r_state != IDLE)) r_overrun <= 1'b1;
    end
  end

  // Returning read data bypasses the FIFO when it is empty so the first pixel
  // is valid the cycle GRAM presents it; a stalled bypass word is pushed and
  // re-presented unchanged from the FIFO head.
  always_comb begin
    w_bypass_tag      = '0;
    w_bypass_tag.sof  = r_if_sof;
    w_bypass_tag.eol  = r_if_eol;
    w_bypass_tag.data = bus.gram_data_i;
  end

  assign w_fifo_nonempty = (w_fifo_count != 2'd0);
  assign w_out_valid     = w_fifo_nonempty || r_inflight;
  assign w_out_tag       = w_fifo_nonempty ? w_fifo_head : w_bypass_tag;
  assign w_fifo_pop      = w_fifo_nonempty && bus.pix_ready_i;
  assign w_fifo_push     = r_inflight && (w_fifo_nonempty || !bus.pix_ready_i);

  pix_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fifo_push),
    .i_data  (w_bypass_tag),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  assign bus.gram_addr_o = w_issue ? r_next_addr : r_held_addr;
  assign bus.pix_valid_o = w_out_valid;
  assign bus.pix_data_o  = w_out_valid ? w_out_tag.data : '0;
  assign bus.pix_sof_o   = w_out_valid && w_out_tag.sof;
  assign bus.pix_eol_o   = w_out_valid && w_out_tag.eol;

  assign busy_o       = (r_state != IDLE);
  assign frame_done_o = w_frame_done;
  assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_gram_scanner.sv
// Directed bench for gram_scanner: GRAM model preloaded with addr[3:0],
// scoreboard of expected tagged pixels popped on each accepted transfer.
`timescale 1ns/1ps
module tb_gram_scanner;

  localparam int unsigned NPIX = 375;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic busy;
  logic frame_done;
  logic overrun;

  gram_scanner_if bus ();

  gram_scanner #(
    .H_PIX     (25),
    .V_PIX     (15),
    .FRAME_DIV (400)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .bus          (bus),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  logic [3:0] gram_mem [NPIX];
  logic [3:0] gram_q = 4'h0;
  initial for (int i = 0; i < NPIX; i++) gram_mem[i] = 4'(i % 16);
  always @(posedge clk)
    gram_q <= (int'(bus.gram_addr_o) < NPIX) ? gram_mem[bus.gram_addr_o] : 4'h0;
  assign bus.gram_data_i = gram_q;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int last_acc_cyc = -10;
  int rdy_mode = 0;
  logic [5:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++)
      exp_q.push_back({(i == 0), ((i % 25) == 24), 4'(i % 16)});
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_cnt < n && k < budget) begin @(negedge clk); k++; end
    check("wait_acc_in_budget", 32'(acc_cnt >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin @(negedge clk); k++; end
    check("wait_done_in_budget", 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_busy(input int budget);
    int k = 0;
    while (busy !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    check("wait_busy_in_budget", 32'(busy), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.pix_ready_i = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       bus.pix_ready_i = 1'b1;
        1:       bus.pix_ready_i = 1'($urandom_range(0, 1));
        default: bus.pix_ready_i = 1'b0;
      endcase
    end
  end

  logic       prev_stall = 1'b0;
  logic [5:0] prev_tag   = '0;
  always @(negedge clk) begin
    logic [5:0] cur;
    cur = {bus.pix_sof_o, bus.pix_eol_o, bus.pix_data_o};
    if (rst_n === 1'b1) begin
      if (prev_stall) begin
        check("stall_valid_hold", 32'(bus.pix_valid_o), 32'd1);
        check("stall_tag_stable", 32'(cur), 32'(prev_tag));
      end
      if (bus.pix_valid_o && bus.pix_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 32'(exp_q.size()), 32'd1);
        end else begin
          check("pix_tag", 32'(cur), 32'(exp_q.pop_front()));
          acc_cnt++;
          last_acc_cyc = cyc;
        end
      end
      if (busy) check("addr_ahead_le2", 32'(int'(bus.gram_addr_o) <= acc_cnt + 2), 32'd1);
      if (frame_done) begin
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_timing", 32'(cyc), 32'(last_acc_cyc + 1));
        done_cnt++;
      end
      prev_stall = bus.pix_valid_o && !bus.pix_ready_i;
      prev_tag   = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    32'(busy),            32'd0);
    check("rst_valid",   32'(bus.pix_valid_o), 32'd0);
    check("rst_addr",    32'(bus.gram_addr_o), 32'd0);
    check("rst_data",    32'(bus.pix_data_o),  32'd0);
    check("rst_sof_eol", 32'({bus.pix_sof_o, bus.pix_eol_o}), 32'd0);
    check("rst_done",    32'(frame_done),      32'd0);
    check("rst_overrun", 32'(overrun),         32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Full frame, ready high: tick latency and contiguous stream.
    push_frame(); acc_cnt = 0; d = done_cnt;
    @(posedge clk); #1 en = 1'b1;
    repeat (399) @(posedge clk);
    @(negedge clk);
    check("t1_idle_at_tick", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_busy_t1",  32'(busy),            32'd1);
    check("t1_valid_t1", 32'(bus.pix_valid_o), 32'd0);
    check("t1_addr_t1",  32'(bus.gram_addr_o), 32'd0);
    @(negedge clk);
    check("t1_valid_t2", 32'(bus.pix_valid_o), 32'd1);
    check("t1_sof_t2",   32'(bus.pix_sof_o),   32'd1);
    check("t1_data_t2",  32'(bus.pix_data_o),  32'd0);
    wait_done(d + 1, 600);
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    check("t1_accepted", 32'(acc_cnt), 32'(NPIX));
    check("t1_idle",     32'(busy),    32'd0);
    check("t1_overrun",  32'(overrun), 32'd0);

    // Long stall at frame start: two reads outstanding, then resume.
    rdy_mode = 2; push_frame(); acc_cnt = 0; d = done_cnt;
    @(posedge clk); #1 en = 1'b1;
    wait_busy(500);
    @(posedge clk); #1 en = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("t6_addr_held", 32'(bus.gram_addr_o), 32'd1);
    check("t6_valid",     32'(bus.pix_valid_o), 32'd1);
    check("t6_head",      32'({bus.pix_sof_o, bus.pix_eol_o, bus.pix_data_o}), 32'h20);
    check("t6_busy",      32'(busy),            32'd1);
    rdy_mode = 0;
    wait_done(d + 1, 600);
    check("t6_accepted", 32'(acc_cnt), 32'(NPIX));

    // Enable drops mid-frame: frame completes, no further frame starts.
    push_frame(); acc_cnt = 0; d = done_cnt;
    @(posedge clk); #1 en = 1'b1;
    wait_acc(100, 1000);
    @(posedge clk); #1 en = 1'b0;
    wait_done(d + 1, 600);
    check("t4_accepted", 32'(acc_cnt), 32'(NPIX));
    repeat (500) @(posedge clk);
    @(negedge clk);
    check("t4_stays_idle", 32'(busy),     32'd0);
    check("t4_one_frame",  32'(done_cnt), 32'(d + 1));
    check("t4_overrun",    32'(overrun),  32'd0);

    // Random backpressure with enable held: frame outlasts the tick period.
    rdy_mode = 1; push_frame(); acc_cnt = 0; d = done_cnt;
    @(posedge clk); #1 en = 1'b1;
    wait_done(d + 1, 3000);
    @(posedge clk); #1 en = 1'b0;
    rdy_mode = 0;
    check("t2_accepted", 32'(acc_cnt), 32'(NPIX));
    check("t3_overrun",  32'(overrun), 32'd1);
    repeat (450) @(posedge clk);
    @(negedge clk);
    check("t3_overrun_sticky", 32'(overrun),  32'd1);
    check("t3_no_restart",     32'(done_cnt), 32'(d + 1));

    // Reset mid-frame under stall, then a clean frame.
    push_frame(); acc_cnt = 0; d = done_cnt;
    @(posedge clk); #1 en = 1'b1;
    wait_acc(200, 1000);
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_stalled_valid", 32'(bus.pix_valid_o), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t5_rst_busy",    32'(busy),            32'd0);
    check("t5_rst_valid",   32'(bus.pix_valid_o), 32'd0);
    check("t5_rst_addr",    32'(bus.gram_addr_o), 32'd0);
    check("t5_rst_data",    32'(bus.pix_data_o),  32'd0);
    check("t5_rst_done",    32'(frame_done),      32'd0);
    check("t5_rst_overrun", 32'(overrun),         32'd0);
    exp_q.delete();
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; rdy_mode = 0;
    check("t5_no_partial_done", 32'(done_cnt), 32'(d));
    push_frame(); acc_cnt = 0;
    @(posedge clk); #1 en = 1'b1;
    wait_done(d + 1, 1000);
    @(posedge clk); #1 en = 1'b0;
    check("t5_accepted", 32'(acc_cnt), 32'(NPIX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
